regfile_wr_sched: RTL

//  Write-port scheduler and clear sequencer for the 32x32 register file.
//  - Zeroes every register after reset, or on request. The register file has no reset of its own.
//  - Shares the single write port (RegWrite/regW/Wdat) between two requesters, core writeback (0) and debug/test writer (1), using round-robin arbitration.
//  - Sits between the writeback stage and the register file. rf_* outputs drive the file's write port directly.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arb2.sv | 21 ++
 rtl/regfile_wr_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file write scheduler.
//   DATA_W / ADDR_W / NREG : register file geometry (32 x 32)
//   state_t                : scheduler state (CLEAR sweeps the file, RUN arbitrates)
//   REQ_CORE / REQ_DBG     : requester indices on the shared write port
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_DBG  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0] : request vector
//   ptr      : index favoured when both request
//   en       : when low, no grant is issued
//   gnt[1:0] : one-hot or zero grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler and clear sequencer for the 32x32 register file.
// After reset (or on clr_start) every register is written with zero; otherwise
// the single write port is shared round-robin between core writeback (0) and
// the debug/test writer (1).
//   clk, rst           : clock, asynchronous active-high reset
//   clr_start          : request a full clear (honoured only in RUN)
//   req_valid/addr/data: two packed requesters, req_ready is the grant
//   rf_we/waddr/wdata  : registered write port of the register file
//   busy               : high while clearing
//   clr_done           : pulse while the last clear write is presented
module regfile_wr_sched #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                busy,
  output logic                clr_done
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rr_ptr;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              hs;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // A clear request in RUN suppresses any grant in the same cycle.
  assign arb_en = (state == RUN) && !clr_start;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign busy      = (state == CLEAR);
  assign hs        = |gnt;
  assign win       = gnt[REQ_DBG];
  assign win_addr  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign win_data  = win ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

  // Clear sweep / arbitration FSM with registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      rr_ptr   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= cnt;
          rf_wdata <= '0;
          clr_done <= (cnt == LAST_ADDR);
          if (cnt == LAST_ADDR) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
            rf_we <= 1'b0;
          end else if (hs) begin
            // r0 is hardwired zero: accept the request but drop the write.
            rf_we    <= (win_addr != '0);
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
            rr_ptr   <= ~win;
          end else begin
            rf_we <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
